// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer
//   Multi-cycle instruction sequencer. Owns the program counter and steps
//   NUM_PHASES execution phases per instruction (default: fetch, register
//   read, memory, writeback). Handles stall, condition-fail skip, flush,
//   branch/link redirect and keeps wrapping retire/skip counters.
//
// Ports
//   clk            in   rising-edge clock
//   nreset         in   asynchronous active-low reset
//   stall          in   hold current phase, nothing advances
//   flush          in   abort current instruction, return to phase 0
//   cond_pass      in   condition result, only looked at in phase 1
//   branch_valid   in   take branch_target at commit
//   branch_target  in   next PC when the branch is taken
//   link_en        in   branch-and-link: request return-address write
//   pc             out  current instruction address (registered)
//   phase          out  current phase index (registered)
//   phase_en       out  one-hot of phase (registered)
//   commit         out  instruction completes this cycle (combinational)
//   link_we        out  write link_addr to R14 this cycle (combinational)
//   link_addr      out  pc + PC_STEP, wrapping (combinational)
//   retired_count  out  committed instructions, wraps
//   skipped_count  out  condition-failed instructions, wraps
module cpu_phase_sequencer #(
    parameter int                ADDR_W     = 32,
    parameter int                PC_STEP    = 4,
    parameter int                NUM_PHASES = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                CNT_W      = 16,
    localparam int               PH_W       = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              stall,
    input  logic              flush,
    input  logic              cond_pass,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              link_en,
    output logic [ADDR_W-1:0] pc,
    output logic [PH_W-1:0]   phase,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic              commit,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_addr,
    output logic [CNT_W-1:0]  retired_count,
    output logic [CNT_W-1:0]  skipped_count
);

    localparam logic [ADDR_W-1:0]     STEP      = ADDR_W'(PC_STEP);
    localparam logic [PH_W-1:0]       LAST_PH   = PH_W'(NUM_PHASES - 1);
    localparam logic [PH_W-1:0]       COND_PH   = PH_W'(1);
    localparam logic [NUM_PHASES-1:0] PH0_ONEHOT = NUM_PHASES'(1);

    // One action per edge, resolved in priority order.
    typedef enum logic [2:0] {
        ACT_ADVANCE,
        ACT_COMMIT,
        ACT_SKIP,
        ACT_STALL,
        ACT_FLUSH
    } act_e;

    act_e                  act;
    logic [ADDR_W-1:0]     pc_q,       pc_d;
    logic [PH_W-1:0]       phase_q,    phase_d;
    logic [NUM_PHASES-1:0] phase_en_q, phase_en_d;
    logic [CNT_W-1:0]      retired_q,  retired_d;
    logic [CNT_W-1:0]      skipped_q,  skipped_d;
    logic [ADDR_W-1:0]     pc_inc;

    assign pc_inc = pc_q + STEP;

    always_comb begin
        act = ACT_ADVANCE;
        if (flush)
            act = ACT_FLUSH;
        else if (stall)
            act = ACT_STALL;
        // Skip is checked before commit so it still wins when phase 1 is
        // also the last phase.
        else if (phase_q == COND_PH && !cond_pass)
            act = ACT_SKIP;
        else if (phase_q == LAST_PH)
            act = ACT_COMMIT;
    end

    always_comb begin
        pc_d       = pc_q;
        phase_d    = phase_q;
        phase_en_d = phase_en_q;
        retired_d  = retired_q;
        skipped_d  = skipped_q;
        case (act)
            ACT_FLUSH: begin
                phase_d    = '0;
                phase_en_d = PH0_ONEHOT;
            end
            ACT_STALL: ;
            ACT_SKIP: begin
                phase_d    = '0;
                phase_en_d = PH0_ONEHOT;
                pc_d       = pc_inc;
                skipped_d  = skipped_q + CNT_W'(1);
            end
            ACT_COMMIT: begin
                phase_d    = '0;
                phase_en_d = PH0_ONEHOT;
                pc_d       = branch_valid ? branch_target : pc_inc;
                retired_d  = retired_q + CNT_W'(1);
            end
            default: begin
                // Only reached below the last phase, so the shift stays one-hot.
                phase_d    = phase_q + PH_W'(1);
                phase_en_d = phase_en_q << 1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pc_q       <= RESET_PC;
            phase_q    <= '0;
            phase_en_q <= PH0_ONEHOT;
            retired_q  <= '0;
            skipped_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            phase_q    <= phase_d;
            phase_en_q <= phase_en_d;
            retired_q  <= retired_d;
            skipped_q  <= skipped_d;
        end
    end

    // Reset is combined in so commit/link_we stay low while nreset is held.
    assign commit        = nreset && (act == ACT_COMMIT);
    assign link_we       = commit && branch_valid && link_en;
    assign link_addr     = pc_inc;
    assign pc            = pc_q;
    assign phase         = phase_q;
    assign phase_en      = phase_en_q;
    assign retired_count = retired_q;
    assign skipped_count = skipped_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
module tb_cpu_phase_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // ---------------- instance A: defaults ----------------
    logic        a_nreset, a_stall, a_flush, a_cond, a_bv, a_link;
    logic [31:0] a_target;
    logic [31:0] a_pc, a_laddr;
    logic [1:0]  a_phase;
    logic [3:0]  a_phase_en;
    logic        a_commit, a_lwe;
    logic [15:0] a_ret, a_skp;

    cpu_phase_sequencer u_a (
        .clk(clk), .nreset(a_nreset), .stall(a_stall), .flush(a_flush),
        .cond_pass(a_cond), .branch_valid(a_bv), .branch_target(a_target),
        .link_en(a_link), .pc(a_pc), .phase(a_phase), .phase_en(a_phase_en),
        .commit(a_commit), .link_we(a_lwe), .link_addr(a_laddr),
        .retired_count(a_ret), .skipped_count(a_skp)
    );

    // ---------------- instance B: 2 phases, 4-bit counters ----------------
    logic        b_nreset, b_stall, b_flush, b_cond, b_bv, b_link;
    logic [31:0] b_target;
    logic [31:0] b_pc, b_laddr;
    logic [0:0]  b_phase;
    logic [1:0]  b_phase_en;
    logic        b_commit, b_lwe;
    logic [3:0]  b_ret, b_skp;

    cpu_phase_sequencer #(
        .NUM_PHASES(2),
        .CNT_W(4),
        .RESET_PC(32'hFFFF_FFFC)
    ) u_b (
        .clk(clk), .nreset(b_nreset), .stall(b_stall), .flush(b_flush),
        .cond_pass(b_cond), .branch_valid(b_bv), .branch_target(b_target),
        .link_en(b_link), .pc(b_pc), .phase(b_phase), .phase_en(b_phase_en),
        .commit(b_commit), .link_we(b_lwe), .link_addr(b_laddr),
        .retired_count(b_ret), .skipped_count(b_skp)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        a_nreset = 0; a_stall = 0; a_flush = 0; a_cond = 1; a_bv = 0; a_link = 0; a_target = '0;
        b_nreset = 0; b_stall = 0; b_flush = 0; b_cond = 1; b_bv = 0; b_link = 0; b_target = '0;

        // ---- reset state ----
        steps(2);
        check_eq("a_rst_pc", a_pc, 0);
        check_eq("a_rst_phase", a_phase, 0);
        check_eq("a_rst_phase_en", a_phase_en, 4'b0001);
        check_eq("a_rst_commit", a_commit, 0);
        check_eq("a_rst_link_we", a_lwe, 0);
        check_eq("a_rst_retired", a_ret, 0);
        check_eq("a_rst_skipped", a_skp, 0);
        a_nreset = 1;
        check_eq("a_rel_phase", a_phase, 0);

        // ---- basic sequencing: 0,1,2,3,0 ----
        step();  check_eq("a_seq_ph1", a_phase, 1); check_eq("a_seq_en1", a_phase_en, 4'b0010);
        check_eq("a_seq_commit_ph1", a_commit, 0);
        step();  check_eq("a_seq_ph2", a_phase, 2); check_eq("a_seq_en2", a_phase_en, 4'b0100);
        step();  check_eq("a_seq_ph3", a_phase, 3); check_eq("a_seq_en3", a_phase_en, 4'b1000);
        check_eq("a_seq_commit_ph3", a_commit, 1);
        check_eq("a_seq_lwe_nobranch", a_lwe, 0);
        check_eq("a_seq_laddr", a_laddr, 32'h4);
        step();  check_eq("a_seq_ph0", a_phase, 0); check_eq("a_seq_pc1", a_pc, 32'h4);
        check_eq("a_seq_ret1", a_ret, 1);
        steps(4);
        check_eq("a_seq_pc2", a_pc, 32'h8);
        check_eq("a_seq_ret2", a_ret, 2);

        // ---- stall 3 cycles in phase 2 ----
        steps(2);
        check_eq("a_stall_pre_ph", a_phase, 2);
        a_stall = 1;
        for (int unsigned i = 0; i < 3; i++) begin
            check_eq("a_stall_commit", a_commit, 0);
            step();
            check_eq("a_stall_hold_ph", a_phase, 2);
            check_eq("a_stall_hold_pc", a_pc, 32'h8);
        end
        a_stall = 0;
        step();  check_eq("a_stall_ph3", a_phase, 3); check_eq("a_stall_commit3", a_commit, 1);
        step();  check_eq("a_stall_ph0", a_phase, 0); check_eq("a_stall_pc", a_pc, 32'hC);
        check_eq("a_stall_ret", a_ret, 3);

        // ---- condition-fail skip ----
        step();  check_eq("a_skip_ph1", a_phase, 1);
        a_cond = 0; #1;
        check_eq("a_skip_commit", a_commit, 0);
        step();
        check_eq("a_skip_ph0", a_phase, 0);
        check_eq("a_skip_pc", a_pc, 32'h10);
        check_eq("a_skip_cnt", a_skp, 1);
        check_eq("a_skip_ret", a_ret, 3);
        a_cond = 1;

        // ---- advance to pc=0x20, then branch-and-link ----
        steps(16);
        check_eq("a_bl_pc_pre", a_pc, 32'h20);
        check_eq("a_bl_ret_pre", a_ret, 7);
        steps(2);
        a_cond = 0;  // ignored outside phase 1
        step();
        check_eq("a_cond_ignored_ph3", a_phase, 3);
        check_eq("a_cond_ignored_commit", a_commit, 1);
        a_cond = 1;
        a_link = 1; #1;
        check_eq("a_link_only_lwe", a_lwe, 0);
        a_bv = 1; a_target = 32'h100; #1;
        check_eq("a_bl_lwe", a_lwe, 1);
        check_eq("a_bl_laddr", a_laddr, 32'h24);
        step();
        check_eq("a_bl_pc", a_pc, 32'h100);
        check_eq("a_bl_ph0", a_phase, 0);
        check_eq("a_bl_ret", a_ret, 8);
        check_eq("a_bl_lwe_after", a_lwe, 0);
        a_bv = 0; a_link = 0; a_target = '0;

        // ---- flush wins over stall in phase 2 ----
        steps(2);
        a_stall = 1; a_flush = 1; #1;
        check_eq("a_flush_commit", a_commit, 0);
        step();
        check_eq("a_flush_ph", a_phase, 0);
        check_eq("a_flush_en", a_phase_en, 4'b0001);
        check_eq("a_flush_pc", a_pc, 32'h100);
        check_eq("a_flush_ret", a_ret, 8);
        check_eq("a_flush_skp", a_skp, 1);
        a_stall = 0; a_flush = 0;

        // ---- branch to 0x40 (no link), then reset mid-stall ----
        steps(3);
        a_bv = 1; a_target = 32'h40; #1;
        check_eq("a_b40_lwe", a_lwe, 0);
        step();
        check_eq("a_b40_pc", a_pc, 32'h40);
        a_bv = 0; a_target = '0;
        steps(2);
        a_stall = 1;
        step();
        check_eq("a_rst2_pre_ph", a_phase, 2);
        #2 a_nreset = 0;
        #1;
        check_eq("a_rst2_pc", a_pc, 0);
        check_eq("a_rst2_en", a_phase_en, 4'b0001);
        check_eq("a_rst2_ret", a_ret, 0);
        check_eq("a_rst2_skp", a_skp, 0);
        check_eq("a_rst2_commit", a_commit, 0);
        a_stall = 0;
        step();
        a_nreset = 1;
        step();
        check_eq("a_rst2_first_adv", a_phase, 1);

        // ---- instance B: two phases, pc wrap, counter wrap ----
        check_eq("b_rst_pc", b_pc, 32'hFFFF_FFFC);
        check_eq("b_rst_en", b_phase_en, 2'b01);
        b_nreset = 1;
        step();
        check_eq("b_ph1", b_phase, 1);
        check_eq("b_commit", b_commit, 1);
        check_eq("b_laddr_wrap", b_laddr, 0);
        step();
        check_eq("b_ph0", b_phase, 0);
        check_eq("b_pc_wrap", b_pc, 0);
        check_eq("b_ret1", b_ret, 1);
        for (int unsigned i = 2; i <= 16; i++) begin
            step();
            check_eq("b_loop_ph1", b_phase, 1);
            step();
            check_eq("b_loop_ph0", b_phase, 0);
            check_eq("b_loop_ret", b_ret, 64'(i % 16));
        end
        check_eq("b_pc_16", b_pc, 32'h3C);
        step();
        b_cond = 0; #1;
        check_eq("b_skip_commit", b_commit, 0);
        step();
        check_eq("b_skip_ph", b_phase, 0);
        check_eq("b_skip_pc", b_pc, 32'h40);
        check_eq("b_skip_cnt", b_skp, 1);
        check_eq("b_skip_ret", b_ret, 0);
        b_cond = 1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
